dither_gen: RTL

DITHER_GEN -- requirements
Module: dither_gen

---
 rtl/dither_gen.sv | 106 ++++++++++
 1 files changed

// File: rtl/dither_gen.sv
// Dithered duty-word generator for a 64-count DPWM: spreads a 1/8-LSB fraction
// over an 8-period frame using a bit-reversed index, with frame-aligned command updates.
module dither_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [8:0] duty_cmd,
    input  logic       cmd_valid,
    output logic [5:0] d_n_input,
    output logic       period_start,
    output logic       frame_start,
    output logic       busy
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e     state_q;
    logic [5:0] pcnt_q;
    logic [2:0] idx_q;
    logic [8:0] act_q;
    logic [8:0] pend_q;
    logic       pend_v_q;
    logic [5:0] d_n_q;
    logic       period_start_q;
    logic       frame_start_q;

    logic       boundary;
    logic       frame_end;
    logic [8:0] act_d;

    // Coarse duty plus the dither bit for period i, saturated so 63 never wraps to 0.
    function automatic logic [5:0] duty_word(input logic [8:0] a, input logic [2:0] i);
        logic       dbit;
        logic [6:0] sum;
        dbit = ({i[0], i[1], i[2]} < a[2:0]);
        sum  = {1'b0, a[8:3]} + {6'd0, dbit};
        return sum[6] ? 6'd63 : sum[5:0];
    endfunction

    assign boundary  = (pcnt_q == 6'd63);
    assign frame_end = (idx_q == 3'd7);
    assign act_d     = pend_v_q ? pend_q : act_q;

    // NOTE: every register sits behind the async reset; nothing here is a memory array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            pcnt_q         <= 6'd0;
            idx_q          <= 3'd0;
            act_q          <= 9'd0;
            pend_q         <= 9'd0;
            pend_v_q       <= 1'b0;
            d_n_q          <= 6'd0;
            period_start_q <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            pcnt_q         <= pcnt_q + 6'd1;
            // Pulses are registered one count early so they are high while pcnt==63.
            period_start_q <= (pcnt_q == 6'd62);
            frame_start_q  <= (pcnt_q == 6'd62) && (idx_q == 3'd7) && (state_q == RUN);

            case (state_q)
                IDLE: begin
                    if (boundary && en) begin
                        state_q  <= RUN;
                        idx_q    <= 3'd0;
                        act_q    <= act_d;
                        pend_v_q <= 1'b0;
                        d_n_q    <= duty_word(act_d, 3'd0);
                    end
                end
                RUN: begin
                    if (boundary) begin
                        if (!en) begin
                            state_q <= IDLE;
                            idx_q   <= 3'd0;
                            d_n_q   <= 6'd0;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            if (frame_end) begin
                                act_q    <= act_d;
                                pend_v_q <= 1'b0;
                                d_n_q    <= duty_word(act_d, 3'd0);
                            end else begin
                                d_n_q <= duty_word(act_q, idx_q + 3'd1);
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // NOTE: placed after the transfer so a same-cycle strobe wins over the pend_v clear.
            if (cmd_valid) begin
                pend_q   <= duty_cmd;
                pend_v_q <= 1'b1;
            end
        end
    end

    assign d_n_input    = d_n_q;
    assign period_start = period_start_q;
    assign frame_start  = frame_start_q;
    assign busy         = (state_q == RUN);

endmodule
